// File: rtl/pll_rst_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_rst_pkg;

    // Sequencer states, in the order a clean start walks through them.
    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    // Width of the lock-timeout retry counter.
    localparam int RETRY_W = 8;

endpackage

// File: rtl/pll_reset_ctrl_if.sv
// Control/status bundle between the PLL reset sequencer and its neighbours.
interface pll_reset_ctrl_if;
    import pll_rst_pkg::*;

    logic               locked;     // from PLL, asynchronous to refclk
    logic               lost_clr;   // software clear of lock_lost
    logic               pll_rst;    // to PLL reset input
    logic               sys_rst;    // system reset, refclk domain
    logic               sys_ready;  // high while running
    logic               lock_lost;  // sticky lock-loss flag
    logic [RETRY_W-1:0] retry_cnt;  // saturating lock-timeout count

    // Sequencer side.
    modport master (
        input  locked, lost_clr,
        output pll_rst, sys_rst, sys_ready, lock_lost, retry_cnt
    );

    // PLL / software side.
    modport slave (
        output locked, lost_clr,
        input  pll_rst, sys_rst, sys_ready, lock_lost, retry_cnt
    );

endinterface

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer for control-signal crossings.
module sync_2ff #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first one a full cycle to settle.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for stable lock, releases
// the system reset, and re-resets the PLL on lock timeout or lock loss.
module pll_reset_ctrl
    import pll_rst_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int CNT_W          = 20
) (
    input  logic             refclk,
    input  logic             rst,
    pll_reset_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               locked_s;
    logic               retry_inc;
    logic               lost_set;
    logic               pll_rst_d, sys_rst_d, sys_ready_d;

    sync_2ff #(.RESET_VAL(1'b0)) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (bus.locked),
        .q   (locked_s)
    );

    // State register and the shared cycle counter.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q <= PLL_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; lock checks take priority over counter expiry.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        retry_inc = 1'b0;
        lost_set  = 1'b0;
        unique case (state_q)
            PLL_RST: begin
                if (cnt_q == PLL_RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = PLL_RST;
                    retry_inc = 1'b1;
                end
            end
            STABLE: begin
                if (!locked_s)                 state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = RUN;
            end
            RUN: begin
                cnt_d = '0;
                if (!locked_s) begin
                    state_d  = PLL_RST;
                    lost_set = 1'b1;
                end
            end
            default: state_d = PLL_RST;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Output decode from the next state, so the registered outputs track state_q exactly.
    always_comb begin
        pll_rst_d   = (state_d == PLL_RST);
        sys_rst_d   = (state_d != RUN);
        sys_ready_d = (state_d == RUN);
    end

    // Registered reset outputs, glitch-free toward the PLL and the system.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            bus.pll_rst   <= 1'b1;
            bus.sys_rst   <= 1'b1;
            bus.sys_ready <= 1'b0;
        end else begin
            bus.pll_rst   <= pll_rst_d;
            bus.sys_rst   <= sys_rst_d;
            bus.sys_ready <= sys_ready_d;
        end
    end

    // Status: sticky lock-loss flag (set beats clear) and saturating retry count.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            bus.lock_lost <= 1'b0;
            bus.retry_cnt <= '0;
        end else begin
            if (lost_set)          bus.lock_lost <= 1'b1;
            else if (bus.lost_clr) bus.lock_lost <= 1'b0;
            if (retry_inc && (bus.retry_cnt != '1))
                bus.retry_cnt <= bus.retry_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl with small sequencing parameters.
module tb_pll_reset_ctrl;
    import pll_rst_pkg::*;

    logic refclk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n;
    int   exp_retry;

    pll_reset_ctrl_if bus ();

    pll_reset_ctrl #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (20),
        .STABLE_CYCLES  (8),
        .CNT_W          (20)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus)
    );

    initial begin
        refclk = 1'b0;
        forever #10 refclk = ~refclk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge, then settle 1 ns so outputs are sampled away from the edge.
    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    // Steps until the selected output (0: pll_rst, 1: sys_rst) equals want; n = edges taken.
    task automatic wait_for(input int sel, input logic want, input int budget, output int cnt);
        cnt = 0;
        while (((sel == 0) ? bus.pll_rst : bus.sys_rst) !== want && cnt < budget) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.locked   = 1'b0;
        bus.lost_clr = 1'b0;
        step();
        step();
        check("rst_pll_rst",   bus.pll_rst,   1);
        check("rst_sys_rst",   bus.sys_rst,   1);
        check("rst_sys_ready", bus.sys_ready, 0);
        check("rst_lock_lost", bus.lock_lost, 0);
        check("rst_retry",     bus.retry_cnt, 0);

        // Normal start: PLL reset for 4 edges, lock 3 cycles later, RUN 11 edges after that.
        rst = 1'b0;
        wait_for(0, 1'b0, 50, n);
        check("start_pll_rst_edges", n, 4);
        step(); step(); step();
        check("start_wait_sys_rst", bus.sys_rst, 1);
        bus.locked = 1'b1;
        wait_for(1, 1'b0, 50, n);
        check("start_lock_to_run", n, 11);
        check("start_sys_ready", bus.sys_ready, 1);
        check("start_pll_rst_low", bus.pll_rst, 0);
        check("start_retry", bus.retry_cnt, 0);

        // Loss in RUN with lost_clr colliding on the set edge.
        bus.locked = 1'b0;
        step();
        check("loss_k_sys_rst", bus.sys_rst, 0);
        step();
        check("loss_k1_lock_lost", bus.lock_lost, 0);
        bus.lost_clr = 1'b1;
        step();
        check("loss_k2_sys_rst",   bus.sys_rst,   1);
        check("loss_k2_pll_rst",   bus.pll_rst,   1);
        check("loss_k2_sys_ready", bus.sys_ready, 0);
        check("loss_set_beats_clr", bus.lock_lost, 1);
        bus.lost_clr = 1'b0;
        step();
        check("loss_sticky", bus.lock_lost, 1);
        bus.lost_clr = 1'b1;
        step();
        bus.lost_clr = 1'b0;
        check("loss_cleared", bus.lock_lost, 0);
        check("loss_retry", bus.retry_cnt, 0);

        // Unstable lock: 3-cycle drop in the middle of STABLE sends it back to WAIT_LOCK.
        wait_for(0, 1'b0, 50, n);
        check("unst_pll_rst_low", bus.pll_rst, 0);
        bus.locked = 1'b1;
        repeat (7) step();
        check("unst_mid_stable_sys_rst", bus.sys_rst, 1);
        bus.locked = 1'b0;
        step(); step(); step();
        bus.locked = 1'b1;
        check("unst_after_drop_sys_rst", bus.sys_rst, 1);
        check("unst_after_drop_pll_rst", bus.pll_rst, 0);
        wait_for(1, 1'b0, 50, n);
        check("unst_relock_to_run", n, 11);
        check("unst_retry", bus.retry_cnt, 0);

        // Second loss, left uncleared, then hold lock low through many timeouts.
        bus.locked = 1'b0;
        wait_for(0, 1'b1, 10, n);
        check("loss2_latency", n, 3);
        check("loss2_lock_lost", bus.lock_lost, 1);
        exp_retry = 0;
        for (int i = 1; i <= 260; i++) begin
            wait_for(0, 1'b0, 50, n);
            check("retry_pll_rst_edges", n, 4);
            wait_for(0, 1'b1, 50, n);
            check("retry_wait_lock_edges", n, 20);
            exp_retry = (exp_retry == 255) ? 255 : exp_retry + 1;
            check("retry_cnt", bus.retry_cnt, exp_retry);
        end
        check("retry_sat", bus.retry_cnt, 255);
        check("retry_lock_lost_sticky", bus.lock_lost, 1);
        check("retry_sys_rst", bus.sys_rst, 1);

        // Lock raised at the start of PLL_RST: RUN after 13 edges.
        bus.locked = 1'b1;
        wait_for(1, 1'b0, 50, n);
        check("relock_to_run", n, 13);
        check("relock_sys_ready", bus.sys_ready, 1);

        // Asynchronous reset between edges while in RUN.
        #5;
        rst = 1'b1;
        #1;
        check("arst_pll_rst",   bus.pll_rst,   1);
        check("arst_sys_rst",   bus.sys_rst,   1);
        check("arst_sys_ready", bus.sys_ready, 0);
        check("arst_lock_lost", bus.lock_lost, 0);
        check("arst_retry",     bus.retry_cnt, 0);
        #3;
        rst = 1'b0;
        wait_for(0, 1'b0, 50, n);
        check("arst_pll_rst_edges", n, 4);
        wait_for(1, 1'b0, 50, n);
        check("arst_lock_to_run", n, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
